// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // A load result is not available from Exec, so a load match falls back to the Mem check.
    function automatic logic [1:0] fwd_select(input logic ex_match, input logic ex_is_load,
                                              input logic mem_match);
        logic [1:0] sel;
        if (ex_match && !ex_is_load) begin
            sel = FWD_MEM;
        end else if (mem_match) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One-source dependency comparator against the Exec and Mem destinations; x0 never matches.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 use_rs,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wen,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_wen,
    output logic                 ex_match,
    output logic                 mem_match
);

    logic src_live_s;

    // Source participates only when read and not the hardwired zero register
    always_comb begin
        src_live_s = use_rs && (rs != {REG_IDX_W{1'b0}});
        ex_match   = src_live_s && ex_wen  && (rs == ex_rd);
        mem_match  = src_live_s && mem_wen && (rs == mem_rd);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline-wide stall/bubble/flush control, registered forwarding selects and halt sequencing.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wen,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_wen,
    input  logic                 redirect,
    input  logic                 halt_fetch,
    output logic                 stall,
    output logic                 bubble,
    output logic                 flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_e       state_r, state_next_s;
    logic [DCNT_W-1:0] drain_r, drain_next_s;
    logic [1:0]        fwd_a_r, fwd_b_r;
    logic              halted_r;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
    logic              ex_match_a_s, mem_match_a_s, ex_match_b_s, mem_match_b_s;
    logic              load_use_s, lu_stall_s;
    logic              stall_s, bubble_s, flush_s;

    hazard_cmp u_cmp_rs1 (
        .rs        (dec_rs1),
        .use_rs    (dec_use_rs1),
        .ex_rd     (ex_rd),
        .ex_wen    (ex_wen),
        .mem_rd    (mem_rd),
        .mem_wen   (mem_wen),
        .ex_match  (ex_match_a_s),
        .mem_match (mem_match_a_s)
    );

    hazard_cmp u_cmp_rs2 (
        .rs        (dec_rs2),
        .use_rs    (dec_use_rs2),
        .ex_rd     (ex_rd),
        .ex_wen    (ex_wen),
        .mem_rd    (mem_rd),
        .mem_wen   (mem_wen),
        .ex_match  (ex_match_b_s),
        .mem_match (mem_match_b_s)
    );

    assign load_use_s = dec_valid && ex_is_load && (ex_match_a_s || ex_match_b_s);

    // Next-state and pipeline controls; redirect outranks halt, halt outranks load-use
    always_comb begin
        state_next_s = state_r;
        drain_next_s = drain_r;
        stall_s      = 1'b0;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        lu_stall_s   = 1'b0;
        if (rst) begin
            state_next_s = ST_RUN;
            drain_next_s = {DCNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect) begin
                        flush_s = 1'b1;
                    end else if (halt_fetch) begin
                        state_next_s = ST_DRAIN;
                        drain_next_s = DRAIN_LOAD;
                    end else if (load_use_s) begin
                        stall_s    = 1'b1;
                        bubble_s   = 1'b1;
                        lu_stall_s = 1'b1;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        flush_s      = 1'b1;
                        state_next_s = ST_RUN;
                        drain_next_s = {DCNT_W{1'b0}};
                    end else begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        if (drain_r == {DCNT_W{1'b0}}) begin
                            state_next_s = ST_HALTED;
                        end else begin
                            drain_next_s = drain_r - DCNT_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                end
                default: begin
                    state_next_s = ST_RUN;
                    drain_next_s = {DCNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, forwarding selects, halted flag and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drain_r     <= {DCNT_W{1'b0}};
            fwd_a_r     <= FWD_RF;
            fwd_b_r     <= FWD_RF;
            halted_r    <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            drain_r  <= drain_next_s;
            halted_r <= (state_next_s == ST_HALTED);
            if (bubble_s || flush_s) begin
                fwd_a_r <= FWD_RF;
                fwd_b_r <= FWD_RF;
            end else begin
                fwd_a_r <= fwd_select(ex_match_a_s, ex_is_load, mem_match_a_s);
                fwd_b_r <= fwd_select(ex_match_b_s, ex_is_load, mem_match_b_s);
            end
            if (lu_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall     = stall_s;
    assign bubble    = bubble_s;
    assign flush     = flush_s;
    assign fwd_a     = fwd_a_r;
    assign fwd_b     = fwd_b_r;
    assign halted    = halted_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 4;

    logic       clk;
    logic       rst;
    logic       dec_valid, dec_use_rs1, dec_use_rs2;
    logic [4:0] dec_rs1, dec_rs2, ex_rd, mem_rd;
    logic       ex_wen, ex_is_load, mem_wen, redirect, halt_fetch;

    logic        stall, bubble, flush, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_stall, d2_bubble, d2_flush, d2_halted;
    logic [1:0]  d2_fwd_a, d2_fwd_b;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_mode;      // 0 running, 1 draining, 2 halted
    int m_left;      // drain cycles still to go after the current one
    int m_fa, m_fb, m_halted;
    int m_sc, m_fc, m_sc2, m_fc2;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .redirect(redirect),
        .halt_fetch(halt_fetch), .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .redirect(redirect),
        .halt_fetch(halt_fetch), .stall(d2_stall), .bubble(d2_bubble), .flush(d2_flush),
        .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .halted(d2_halted), .stall_cnt(d2_stall_cnt),
        .flush_cnt(d2_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_hits(input logic use_r, input logic [4:0] rs,
                                    input logic [4:0] rd, input logic wen);
        return use_r && (rs != 5'd0) && (rs == rd) && wen;
    endfunction

    function automatic int fwd_of(input bit ex_hit, input bit mem_hit, input logic is_load);
        if (ex_hit && !is_load) return 1;
        if (mem_hit) return 2;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_fa = 0; m_fb = 0; m_halted = 0;
        m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    endtask

    task automatic idle();
        rst = 1'b0; dec_valid = 1'b0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        ex_wen = 1'b0; ex_is_load = 1'b0; mem_wen = 1'b0; redirect = 1'b0; halt_fetch = 1'b0;
    endtask

    // One cycle: check outputs against the model, clock, advance the model.
    task automatic step();
        bit ea, eb, ma, mb, lu;
        int e_st, e_fl;
        #1;
        ea = src_hits(dec_use_rs1, dec_rs1, ex_rd, ex_wen);
        eb = src_hits(dec_use_rs2, dec_rs2, ex_rd, ex_wen);
        ma = src_hits(dec_use_rs1, dec_rs1, mem_rd, mem_wen);
        mb = src_hits(dec_use_rs2, dec_rs2, mem_rd, mem_wen);
        lu = 1'b0; e_st = 0; e_fl = 0;
        if (!rst) begin
            if (m_mode == 2) e_st = 1;
            else if (redirect) e_fl = 1;
            else if (m_mode == 1) e_st = 1;
            else if (halt_fetch) e_st = 0;
            else if (dec_valid && ex_is_load && (ea || eb)) begin e_st = 1; lu = 1'b1; end
        end
        chk("stall", stall, e_st);
        chk("bubble", bubble, e_st);
        chk("flush", flush, e_fl);
        chk("fwd_a", fwd_a, m_fa);
        chk("fwd_b", fwd_b, m_fb);
        chk("halted", halted, m_halted);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
        chk("stall_cnt_w2", d2_stall_cnt, m_sc2);
        chk("flush_cnt_w2", d2_flush_cnt, m_fc2);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_st != 0 || e_fl != 0) begin
                m_fa = 0; m_fb = 0;
            end else begin
                m_fa = fwd_of(ea, ma, ex_is_load);
                m_fb = fwd_of(eb, mb, ex_is_load);
            end
            if (lu) begin m_sc = sat_inc(m_sc, 65535); m_sc2 = sat_inc(m_sc2, 3); end
            if (e_fl != 0) begin m_fc = sat_inc(m_fc, 65535); m_fc2 = sat_inc(m_fc2, 3); end
            if (m_mode == 0) begin
                if (!redirect && halt_fetch) begin m_mode = 1; m_left = DRAIN - 1; end
            end else if (m_mode == 1) begin
                if (redirect) m_mode = 0;
                else if (m_left == 0) m_mode = 2;
                else m_left--;
            end
            m_halted = (m_mode == 2);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();                       // reset held: controls forced low
        idle();
        step();

        // Back-to-back ALU dependency, then Mem-only producer
        dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd5; ex_rd = 5'd5; ex_wen = 1'b1;
        step();
        chk("alu_dep_fwd_a", fwd_a, 32'd1);
        ex_wen = 1'b0; mem_rd = 5'd5; mem_wen = 1'b1;
        step();
        chk("mem_dep_fwd_a", fwd_a, 32'd2);

        // Load-use: one stall cycle, then forward from WB path
        idle();
        dec_valid = 1'b1; dec_use_rs2 = 1'b1; dec_rs2 = 5'd7;
        ex_rd = 5'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        #1;
        chk("lu_stall", stall, 32'd1);
        step();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        ex_wen = 1'b0; ex_is_load = 1'b0; mem_rd = 5'd7; mem_wen = 1'b1;
        step();
        chk("lu_fwd_b", fwd_b, 32'd2);

        // x0 never matches; Exec beats Mem
        idle();
        dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd0; ex_rd = 5'd0; ex_wen = 1'b1;
        step();
        chk("x0_fwd_a", fwd_a, 32'd0);
        dec_rs1 = 5'd3; ex_rd = 5'd3; mem_rd = 5'd3; mem_wen = 1'b1;
        step();
        chk("ex_over_mem", fwd_a, 32'd1);

        // Redirect with concurrent load-use and halt_fetch
        idle();
        dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd9;
        ex_rd = 5'd9; ex_wen = 1'b1; ex_is_load = 1'b1; redirect = 1'b1; halt_fetch = 1'b1;
        #1;
        chk("redir_stall", stall, 32'd0);
        step();
        chk("redir_flush_cnt", flush_cnt, 32'd1);
        idle();
        step();                       // stays running: no stall

        // Halt: four drain cycles, then sticky halted even across redirect
        halt_fetch = 1'b1;
        step();
        idle();
        for (int i = 0; i < DRAIN; i++) step();
        chk("halted_set", halted, 32'd1);
        redirect = 1'b1;
        step();
        step();
        chk("halted_sticky", halted, 32'd1);
        idle();
        rst = 1'b1;
        step();
        idle();
        chk("rst_halted", halted, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        // Redirect on the second drain cycle cancels the halt
        halt_fetch = 1'b1;
        step();
        idle();
        step();
        redirect = 1'b1;
        step();
        idle();
        for (int i = 0; i < DRAIN + 2; i++) step();
        chk("drain_cancel", halted, 32'd0);

        // Saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) begin
            idle();
            dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd4;
            ex_rd = 5'd4; ex_wen = 1'b1; ex_is_load = 1'b1;
            step();
        end
        chk("sat_stall_w2", d2_stall_cnt, 32'd3);

        // Random traffic with small register indices to provoke collisions
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_use_rs1 = $urandom_range(0, 1);
            dec_use_rs2 = $urandom_range(0, 1);
            dec_rs1     = 5'($urandom_range(0, 6));
            dec_rs2     = 5'($urandom_range(0, 6));
            ex_rd       = 5'($urandom_range(0, 6));
            mem_rd      = 5'($urandom_range(0, 6));
            ex_wen      = $urandom_range(0, 1);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            mem_wen     = $urandom_range(0, 1);
            redirect    = ($urandom_range(0, 7) == 0);
            halt_fetch  = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (IF/Dec/Exec/Mem/WB). It drives the pipeline-wide stall, bubble and flush controls and the registered operand-forwarding selects. It also sequences an orderly halt: when fetch reports a halt, the controller freezes fetch, drains older instructions, then asserts a sticky halted flag. It sits beside the pipeline registers in the top level and consumes per-stage destination/write-enable/load info plus the Mem-stage redirect.

Parameters:
DRAIN_CYCLES, 4, cycles spent in DRAIN before halted asserts (covers Dec..WB)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
dec_valid  in  1  Dec stage holds a real instruction
dec_rs1  in  5  Dec source register 1
dec_rs2  in  5  Dec source register 2
dec_use_rs1  in  1  Dec instruction reads rs1
dec_use_rs2  in  1  Dec instruction reads rs2
ex_rd  in  5  Exec destination register
ex_wen  in  1  Exec writes register file
ex_is_load  in  1  Exec instruction is a load (wb_sel = memory)
mem_rd  in  5  Mem destination register
mem_wen  in  1  Mem writes register file
redirect  in  1  Mem-stage taken branch/jump (npc_control)
halt_fetch  in  1  IF detected halt instruction
stall  out  1  hold PC and IF/Dec register
bubble  out  1  load zero controls into Dec/Exec register
flush  out  1  squash IF/Dec, Dec/Exec, Exec/Mem registers
fwd_a  out  2  operand A source in Exec: 00 regfile, 01 ALU_output_Mem, 10 RWrdata_WB, 11 reserved
fwd_b  out  2  operand B source, same encoding
halted  out  1  sticky, pipeline drained after halt
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, drain counter=0, fwd_a=fwd_b=00, halted=0, both counters=0. stall/bubble/flush are combinational and forced 0 while rst=1.
- Match rule: a source matches a stage when use_rsX=1, rsX!=0, rsX==stage_rd and stage_wen=1. x0 never matches.
- Load-use: in RUN, dec_valid and (rs1 or rs2) matches Exec with ex_is_load=1 -> stall=1 and bubble=1 for exactly that cycle. The next cycle the load is in Mem and the consumer gets fwd=10. stall_cnt increments once per stall cycle.
- Forwarding: fwd_a/fwd_b are registered and load on each edge with Dec/Exec, giving 1-cycle latency, valid in Exec.
  - Exec match (non-load) -> 01.
  - Else Mem match -> 10.
  - Else 00.
  - Exec wins over Mem (youngest producer).
  - WB-distance hazards are covered by the write-through register file: 00.
  - On a bubble or flush cycle both fwd registers load 00.
- FSM states are RUN, DRAIN and HALTED.
  - RUN: redirect=1 -> flush=1 this cycle, flush_cnt+1, stay RUN, and any halt_fetch that cycle is ignored (wrong path). Else halt_fetch=1 -> go to DRAIN and load the counter with DRAIN_CYCLES-1.
  - DRAIN: stall=1 and bubble=1 every cycle; counter decrements; at 0 go to HALTED. If redirect=1 in DRAIN (older branch overrides the halt) -> flush=1, flush_cnt+1, return to RUN.
  - HALTED: halted=1, stall=1, bubble=1, and all other inputs are ignored until rst.
- Priority: rst > redirect > halt_fetch > load-use. On redirect with a simultaneous load-use: flush only, no stall, stall_cnt unchanged.
- Counters saturate at all-ones and do not wrap.
- Reset mid-DRAIN or in HALTED returns to RUN with halted=0 at the next edge.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, DRAIN, HALTED);
  - FWD_RF/FWD_MEM/FWD_WB constants;
  - register-index width 5.
- Sub-module hazard_cmp: one-source comparator giving ex_match/mem_match from rs, use and the stage fields. Instantiate it twice (rs1, rs2).

Test Plan:
- Back-to-back ALU dependency: ex_rd=5, ex_wen=1, dec_rs1=5 -> next cycle fwd_a=01, stall=0. Same with only mem_rd=5 -> fwd_a=10.
- Load-use: ex_rd=7, ex_wen=1, ex_is_load=1, dec_rs2=7 -> stall=bubble=1 for 1 cycle, stall_cnt=1. Then mem_rd=7 match -> fwd_b=10.
- Zero register: dec_rs1=0, ex_rd=0, ex_wen=1 -> fwd_a=00, no stall. Ex and Mem both rd=3 -> fwd=01.
- Redirect with concurrent load-use and halt_fetch -> flush=1, stall=0, flush_cnt=1, state stays RUN.
- halt_fetch in RUN -> stall=bubble=1 for 4 cycles, halted=1 on cycle 5 and sticky. rst pulse -> halted=0, counters 0.
- Redirect on DRAIN cycle 2 -> flush=1, back to RUN, halted never asserts. Counter saturation with CNT_W=2: 5 stalls -> stall_cnt=3.
